// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit, one bit per cycle.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   reset_i      synchronous active-high reset
//   in_valid_i   request valid          in_ready_o  high only in IDLE
//   muldiv_op_i  funct3 (MUL..REMU)     in1_i/in2_i rs1/rs2 operands
//   kill_i       flush; aborts in-flight op and blocks acceptance
//   out_valid_o  result valid (DONE)    out_ready_i consumer accepts result
//   out_o        registered result, held until the next result or reset
//
// Multiply uses right-shifting shift-add on magnitudes; divide uses restoring
// division on magnitudes. Both share one 2*XLEN accumulator. Signs are fixed
// up on the last iteration, as the result is registered.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      muldiv_op_i,
    input  logic [XLEN-1:0] in1_i,
    input  logic [XLEN-1:0] in2_i,
    input  logic            kill_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_o
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Latched request: op plus operand sign flags (already gated by signedness)
    typedef struct packed {
        logic [2:0] op;
        logic       neg1;
        logic       neg2;
    } req_t;

    state_t              state, state_nxt;
    req_t                req;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc;     // mul: {partial hi, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0]     b_q;     // mul: multiplicand magnitude; div: divisor magnitude

    // ---------------- accept-side decode ----------------
    logic            sgn1, sgn2, neg1, neg2, is_div, div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] mag1, mag2, special_res;

    always_comb begin
        sgn1     = !(muldiv_op_i inside {OP_MULHU, OP_DIVU, OP_REMU});
        sgn2     = muldiv_op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        neg1     = sgn1 && in1_i[XLEN-1];
        neg2     = sgn2 && in2_i[XLEN-1];
        // -INT_MIN wraps to INT_MIN, which is the correct unsigned magnitude
        mag1     = neg1 ? -in1_i : in1_i;
        mag2     = neg2 ? -in2_i : in2_i;
        is_div   = muldiv_op_i[2];
        div_zero = is_div && (in2_i == '0);
        div_ovf  = (muldiv_op_i inside {OP_DIV, OP_REM}) && (in1_i == INT_MIN) && (&in2_i);
        special  = div_zero || div_ovf;
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) special_res = muldiv_op_i[1] ? in1_i : '1;
        else          special_res = muldiv_op_i[1] ? '0 : in1_i;
        accept   = (state == IDLE) && in_valid_i && !kill_i;
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] acc_nxt;

    always_comb begin
        // shift-add: add multiplicand into the high half when multiplier LSB is set
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        // restoring divide: bring in the next dividend bit, trial-subtract
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = !div_diff[XLEN];
        div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        if (req.op[2]) acc_nxt = {div_rem, acc[XLEN-2:0], div_ge};
        else           acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end

    // ---------------- final sign fix-up / result select ----------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        prod_s = (req.neg1 ^ req.neg2) ? -acc_nxt : acc_nxt;
        quo    = acc_nxt[XLEN-1:0];
        rem    = acc_nxt[2*XLEN-1:XLEN];
        case (req.op)
            OP_MUL:                      final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             final_res = (req.neg1 ^ req.neg2) ? -quo : quo;
            default:                     final_res = req.neg1 ? -rem : rem;  // REM/REMU
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : BUSY;
            BUSY: begin
                if (kill_i)                        state_nxt = IDLE;
                else if (cnt == CW'(XLEN-1))       state_nxt = DONE;
            end
            DONE: if (kill_i || out_ready_i)       state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            req   <= '0;
            cnt   <= '0;
            acc   <= '0;
            b_q   <= '0;
            out_o <= '0;
        end else begin
            if (accept) begin
                req   <= '{op: muldiv_op_i, neg1: neg1, neg2: neg2};
                cnt   <= '0;
                acc   <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                b_q   <= is_div ? mag2 : mag1;
                if (special) out_o <= special_res;
            end else if (state == BUSY && !kill_i) begin
                acc <= acc_nxt;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(XLEN-1)) out_o <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_i, in_valid_i, in_ready_o, kill_i, out_valid_o, out_ready_i;
    logic [2:0]      muldiv_op_i;
    logic [XLEN-1:0] in1_i, in2_i, out_o;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .muldiv_op_i(muldiv_op_i), .in1_i(in1_i), .in2_i(in2_i), .kill_i(kill_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_o(out_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Independent reference built on simulator integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op, measure latency, stall the result for `stall` cycles, transfer.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int stall,
                         input string nm);
        int n = 0;
        chk({nm, ".in_ready"}, 32'(in_ready_o), 32'd1);
        muldiv_op_i = op; in1_i = a; in2_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
        step();
        in_valid_i = 1'b0;
        while (!out_valid_o && n < 200) begin
            chk({nm, ".early_valid"}, 32'(out_valid_o), 32'd0);
            step();
            n++;
        end
        chk({nm, ".latency"}, 32'(n), 32'(lat));
        chk({nm, ".result"}, out_o, exp);
        for (int s = 0; s < stall; s++) begin
            // a competing request must be ignored while the result waits
            in_valid_i = 1'b1; muldiv_op_i = 3'd0; in1_i = 32'd9; in2_i = 32'd9;
            step();
            chk({nm, ".stall_valid"}, 32'(out_valid_o), 32'd1);
            chk({nm, ".stall_out"}, out_o, exp);
            chk({nm, ".stall_ready"}, 32'(in_ready_o), 32'd0);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk({nm, ".post_valid"}, 32'(out_valid_o), 32'd0);
        chk({nm, ".post_ready"}, 32'(in_ready_o), 32'd1);
        chk({nm, ".hold_out"}, out_o, exp);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, "mul_neg"});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, "mulh_min"});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mulhu_max"});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, "mulhsu"});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32, "mulh_m1"});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32, "div_neg"});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32, "rem_neg"});
        vecs.push_back('{3'd5, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 32, "divu"});
        vecs.push_back('{3'd7, 32'hFFFF_FFF9, 32'd2,          32'h0000_0001, 32, "remu"});
        vecs.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, "div_negdiv"});
        vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32, "rem_negdiv"});
        vecs.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 0,  "divu_zero"});
        vecs.push_back('{3'd6, 32'd5,          32'd0,          32'h0000_0005, 0,  "rem_zero"});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  "div_ovf"});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0,  "rem_ovf"});

        reset_i = 1'b1; in_valid_i = 1'b0; kill_i = 1'b0; out_ready_i = 1'b0;
        muldiv_op_i = '0; in1_i = '0; in2_i = '0;
        step(); step();
        reset_i = 1'b0;
        chk("rst.in_ready", 32'(in_ready_o), 32'd1);
        chk("rst.out_valid", 32'(out_valid_o), 32'd0);
        chk("rst.out", out_o, 32'd0);

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0, vecs[i].name);

        // Backpressure: result held 10 cycles with a competing request present
        do_op(3'd0, 32'd6, 32'd7, 32'd42, 32, 10, "bp_mul");

        // kill in IDLE blocks acceptance
        in_valid_i = 1'b1; kill_i = 1'b1; muldiv_op_i = 3'd0; in1_i = 32'd2; in2_i = 32'd2;
        step();
        in_valid_i = 1'b0; kill_i = 1'b0;
        chk("kill_idle.in_ready", 32'(in_ready_o), 32'd1);

        // kill during BUSY cycle 12
        in_valid_i = 1'b1; muldiv_op_i = 3'd0; in1_i = 32'd5; in2_i = 32'd5;
        step();
        in_valid_i = 1'b0;
        for (int c = 1; c < 12; c++) step();
        chk("kill_busy.in_ready_before", 32'(in_ready_o), 32'd0);
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        chk("kill_busy.in_ready", 32'(in_ready_o), 32'd1);
        chk("kill_busy.out_valid", 32'(out_valid_o), 32'd0);
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                step();
                if (out_valid_o) seen++;
            end
            chk("kill_busy.never_valid", 32'(seen), 32'd0);
        end

        // reset during BUSY cycle 20
        in_valid_i = 1'b1; muldiv_op_i = 3'd4; in1_i = 32'd100; in2_i = 32'd7;
        step();
        in_valid_i = 1'b0;
        for (int c = 1; c < 20; c++) step();
        reset_i = 1'b1;
        in_valid_i = 1'b1;  // ignored under reset
        step();
        reset_i = 1'b0; in_valid_i = 1'b0;
        chk("rst_busy.in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_busy.out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_busy.out", out_o, 32'd0);
        do_op(3'd0, 32'd3, 32'd4, 32'd12, 32, 0, "post_rst_mul");

        // Random back-to-back against the reference model
        for (int k = 0; k < 250; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic        spc;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'd0; 1: a = 32'h8000_0000; 2: a = 32'hFFFF_FFFF;
                3: a = 32'h7FFF_FFFF; default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0; 1: b = 32'hFFFF_FFFF; 2: b = 32'd1;
                3: b = 32'h8000_0000; default: b = $urandom;
            endcase
            spc = (op[2] && b == 0) ||
                  ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            do_op(op, a, b, model(op, a, b), spc ? 0 : 32, $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
